// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM state encoding, owner and
// one-hot grant constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } state_e;

  // Owner of the transaction in flight (also the last-grant encoding).
  localparam logic OwnIfu = 1'b0;
  localparam logic OwnLsu = 1'b1;

  // One-hot grant vector: bit 0 = IFU, bit 1 = LSU.
  localparam logic [1:0] GntNone = 2'b00;
  localparam logic [1:0] GntIfu  = 2'b01;
  localparam logic [1:0] GntLsu  = 2'b10;

endpackage

// File: rtl/arb_pick.sv
// Two-input request selector. A lone requester always wins. On a tie the LSU
// wins, unless MEM_ARB_RR_EN is defined, in which case the requester that was
// not granted last wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
`ifdef MEM_ARB_RR_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant
);

  // One-hot grant from the current valids and the tie rule.
  always_comb begin
    grant = GntNone;
    if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_RR_EN
      grant = (last_grant == OwnLsu) ? GntIfu : GntLsu;
`else
      grant = GntLsu;
`endif
    end else if (ifu_valid) begin
      grant = GntIfu;
    end else if (lsu_valid) begin
      grant = GntLsu;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single data-memory port between IFU fetches and LSU
// loads/stores. One transaction at a time: accept in IDLE, present the latched
// request in REQ until the downstream takes it, then pass the response through
// to the owner in RESP. Optional macro MEM_ARB_RR_EN selects round-robin ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  state_e              state_q, state_d;
  logic                owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [1:0]          grant;
  logic                accept;

`ifdef MEM_ARB_RR_EN
  logic last_q;
`endif

  arb_pick u_arb_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
    .last_grant (last_q),
`endif
    .grant      (grant)
  );

  assign accept = (state_q == StIdle) && (ifu_req_valid || lsu_req_valid);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one transaction walks IDLE -> REQ -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (ifu_req_valid || lsu_req_valid) state_d = StReq;
      StReq:  if (mem_req_ready) state_d = StReq == StReq ? StResp : StReq;
      StResp: if (mem_resp_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Latch the winner's request and ownership on accept; IFU fetches are reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= OwnLsu;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      if (grant == GntLsu) begin
        owner_q <= OwnLsu;
        addr_q  <= lsu_req_addr;
        wen_q   <= lsu_req_wen;
        wdata_q <= lsu_req_wdata;
        wmask_q <= lsu_req_wmask;
      end else begin
        owner_q <= OwnIfu;
        addr_q  <= ifu_req_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember who won the last accept so the next tie goes the other way.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= OwnLsu;
    end else if (accept) begin
      last_q <= (grant == GntLsu) ? OwnLsu : OwnIfu;
    end
  end
`endif

  // Handshake outputs and response routing; responses are a pure pass-through.
  always_comb begin
    ifu_req_ready  = (state_q == StIdle) && (grant == GntIfu);
    lsu_req_ready  = (state_q == StIdle) && (grant == GntLsu);
    mem_req_valid  = (state_q == StReq);
    mem_req_addr   = addr_q;
    mem_req_wen    = wen_q;
    mem_req_wdata  = wdata_q;
    mem_req_wmask  = wmask_q;
    ifu_resp_valid = 1'b0;
    ifu_resp_rdata = '0;
    lsu_resp_valid = 1'b0;
    lsu_resp_rdata = '0;
    if (state_q == StResp) begin
      if (owner_q == OwnIfu) begin
        ifu_resp_valid = mem_resp_valid;
        ifu_resp_rdata = mem_resp_rdata;
      end else begin
        lsu_resp_valid = mem_resp_valid;
        lsu_resp_rdata = mem_resp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model. Honours MEM_ARB_RR_EN for the tie rule.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_rdata;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_rdata (ifu_resp_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_wmask  (lsu_req_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_rdata (lsu_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tie rule from the arbitration policy: does the LSU win this cycle?
  function automatic bit lsu_wins(input bit iv, input bit lv, input bit last_lsu);
    if (iv && lv) begin
`ifdef MEM_ARB_RR_EN
      return !last_lsu;
`else
      return 1'b1;
`endif
    end
    return lv;
  endfunction

  // Transaction-level model: at most one transaction in flight.
  bit          m_ok = 0;
  bit          m_busy, m_sent, m_own_lsu, m_last_lsu;
  logic [31:0] m_addr, m_wdata;
  logic        m_wen;
  logic [3:0]  m_wmask;
  int          n_done = 0;
  bit          ifu_acc = 0, lsu_acc = 0;

  // Compare outputs against the model each cycle, then advance the model by
  // what happens at the next rising edge (inputs are stable until then).
  always @(negedge clk) begin
    bit wl, any;
    ifu_acc = ifu_req_valid && ifu_req_ready;
    lsu_acc = lsu_req_valid && lsu_req_ready;
    wl  = lsu_wins(ifu_req_valid, lsu_req_valid, m_last_lsu);
    any = ifu_req_valid || lsu_req_valid;
    if (m_ok) begin
      chk("m_ifu_req_ready", ifu_req_ready, !m_busy && any && !wl);
      chk("m_lsu_req_ready", lsu_req_ready, !m_busy && any && wl);
      chk("m_mem_req_valid", mem_req_valid, m_busy && !m_sent);
      if (m_busy && !m_sent) begin
        chk("m_mem_req_addr", mem_req_addr, m_addr);
        chk("m_mem_req_wen", mem_req_wen, m_wen);
        chk("m_mem_req_wdata", mem_req_wdata, m_wdata);
        chk("m_mem_req_wmask", mem_req_wmask, m_wmask);
      end
      chk("m_ifu_resp_valid", ifu_resp_valid, m_busy && m_sent && !m_own_lsu && mem_resp_valid);
      chk("m_lsu_resp_valid", lsu_resp_valid, m_busy && m_sent && m_own_lsu && mem_resp_valid);
      if (m_busy && m_sent && mem_resp_valid) begin
        if (m_own_lsu) chk("m_lsu_resp_rdata", lsu_resp_rdata, mem_resp_rdata);
        else chk("m_ifu_resp_rdata", ifu_resp_rdata, mem_resp_rdata);
      end
    end
    if (!rst) begin
      m_ok = 1; m_busy = 0; m_sent = 0; m_own_lsu = 1; m_last_lsu = 1;
      m_addr = 0; m_wen = 0; m_wdata = 0; m_wmask = 0;
    end else if (m_ok) begin
      if (!m_busy) begin
        if (any) begin
          m_busy = 1; m_sent = 0; m_own_lsu = wl; m_last_lsu = wl;
          m_addr  = wl ? lsu_req_addr : ifu_req_addr;
          m_wen   = wl ? lsu_req_wen : 1'b0;
          m_wdata = wl ? lsu_req_wdata : 32'h0;
          m_wmask = wl ? lsu_req_wmask : 4'h0;
        end
      end else if (!m_sent) begin
        if (mem_req_ready) m_sent = 1;
      end else if (mem_resp_valid) begin
        m_busy = 0;
        n_done++;
      end
    end
  end

  bit g[4];
  bit exp_g[4];

  initial begin
    rst = 0;
    ifu_req_valid = 0; ifu_req_addr = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
    tick(); tick();
    rst = 1;

    // Reset state.
    @(negedge clk);
    chk("rst_ifu_ready", ifu_req_ready, 0);
    chk("rst_lsu_ready", lsu_req_ready, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_req_addr, 0);
    chk("rst_ifu_resp", ifu_resp_valid, 0);
    chk("rst_lsu_resp", lsu_resp_valid, 0);

    // IFU only, 3-cycle turnaround.
    tick(); ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    @(negedge clk);
    chk("ifu_ready", ifu_req_ready, 1);
    chk("ifu_lsu_ready", lsu_req_ready, 0);
    tick(); ifu_req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    chk("ifu_mem_valid", mem_req_valid, 1);
    chk("ifu_mem_addr", mem_req_addr, 32'h8000_0000);
    chk("ifu_mem_wen", mem_req_wen, 0);
    chk("ifu_mem_wmask", mem_req_wmask, 0);
    tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0413;
    @(negedge clk);
    chk("ifu_resp_valid", ifu_resp_valid, 1);
    chk("ifu_resp_rdata", ifu_resp_rdata, 32'h0000_0413);
    chk("ifu_lsu_resp", lsu_resp_valid, 0);
    tick(); mem_resp_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
    @(negedge clk);
    chk("ifu_turnaround_ready", ifu_req_ready, 1);
    tick(); ifu_req_valid = 0; mem_req_ready = 1;
    tick(); mem_req_ready = 0; mem_resp_valid = 1;
    tick(); mem_resp_valid = 0;

    // LSU store.
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF;
    @(negedge clk);
    chk("st_lsu_ready", lsu_req_ready, 1);
    chk("st_ifu_ready", ifu_req_ready, 0);
    tick(); lsu_req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    chk("st_mem_valid", mem_req_valid, 1);
    chk("st_mem_wen", mem_req_wen, 1);
    chk("st_mem_addr", mem_req_addr, 32'h8000_1000);
    chk("st_mem_wdata", mem_req_wdata, 32'hDEAD_BEEF);
    chk("st_mem_wmask", mem_req_wmask, 4'hF);
    tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("st_lsu_resp", lsu_resp_valid, 1);
    chk("st_lsu_rdata", lsu_resp_rdata, 32'h1234_5678);
    chk("st_ifu_resp", ifu_resp_valid, 0);
    tick(); mem_resp_valid = 0;

    // Tie for four transactions; last grant was LSU.
`ifdef MEM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{1, 1, 1, 1};
`endif
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_2100; lsu_req_wmask = 0;
    mem_req_ready = 1; mem_resp_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bit found;
      found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
        @(negedge clk);
        if (ifu_req_ready || lsu_req_ready) begin
          g[i] = lsu_req_ready;
          found = 1;
        end
        tick();
      end
      if (!found) chk("tie_grant_timeout", 0, 1);
      else chk($sformatf("tie_grant%0d_is_lsu", i), g[i], exp_g[i]);
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    tick(); tick();
    mem_req_ready = 0; mem_resp_valid = 0;

    // Backpressure: request held for 5 cycles while both requesters wait.
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 0;
    @(negedge clk);
    chk("bp_lsu_ready", lsu_req_ready, 1);
    tick(); ifu_req_valid = 1; lsu_req_addr = 32'h8000_3000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_mem_valid", mem_req_valid, 1);
      chk("bp_mem_addr", mem_req_addr, 32'h8000_2000);
      chk("bp_mem_wen", mem_req_wen, 0);
      chk("bp_ifu_ready", ifu_req_ready, 0);
      chk("bp_lsu_ready_low", lsu_req_ready, 0);
      tick();
    end
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1;
    tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("bp_lsu_resp", lsu_resp_valid, 1);
    chk("bp_lsu_rdata", lsu_resp_rdata, 32'hCAFE_F00D);
    tick(); mem_resp_valid = 0;

    // Reset while in RESP abandons the transaction.
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0010;
    tick(); ifu_req_valid = 0; mem_req_ready = 1;
    tick(); mem_req_ready = 0; rst = 0;
    @(negedge clk);
    chk("rr_in_resp_mem_valid", mem_req_valid, 0);
    tick(); rst = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("rr_ifu_resp", ifu_resp_valid, 0);
    chk("rr_lsu_resp", lsu_resp_valid, 0);
    chk("rr_mem_valid", mem_req_valid, 0);
    tick(); mem_resp_valid = 0;

    // Spurious response in IDLE.
    tick(); mem_resp_valid = 1;
    @(negedge clk);
    chk("sp_ifu_resp", ifu_resp_valid, 0);
    chk("sp_lsu_resp", lsu_resp_valid, 0);
    tick(); mem_resp_valid = 0;

    // Randomized traffic; requesters hold requests until accepted.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) != 0);
      if (!ifu_req_valid || ifu_acc) begin
        ifu_req_valid = ($urandom_range(0, 1) == 0);
        ifu_req_addr  = $urandom & 32'hFFFF_FFFC;
      end
      if (!lsu_req_valid || lsu_acc) begin
        lsu_req_valid = ($urandom_range(0, 1) == 0);
        lsu_req_addr  = $urandom;
        lsu_req_wen   = $urandom_range(0, 1) == 1;
        lsu_req_wdata = $urandom;
        lsu_req_wmask = 4'($urandom);
      end
      mem_req_ready  = ($urandom_range(0, 2) != 0);
      mem_resp_valid = ($urandom_range(0, 2) == 0);
      mem_resp_rdata = $urandom;
    end
    tick();
    chk("rand_progress", n_done > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single data-memory port between the IFU (instruction fetch, read-only) and the LSU (loads/stores). Accepts at most one transaction at a time, forwards it to the downstream memory port (the DPI `pmem_read`/`pmem_write` wrapper or a bus bridge), and routes the response back to the requester that owns it. Sits between IFU/LSU and memory in the NPC core.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; write mask is DATA_W/8 bits

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset rst, synchronous, active-low
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch data valid
- ifu_resp_rdata  out  DATA_W  fetched instruction
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  load/store address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  DATA_W  store data
- lsu_req_wmask  in  DATA_W/8  byte-enable mask
- lsu_resp_valid  out  1  load data / store ack valid
- lsu_resp_rdata  out  DATA_W  load data (store ack: passes mem_resp_rdata unchanged)
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts request
- mem_req_addr  out  ADDR_W  registered address
- mem_req_wen  out  1  registered write enable (0 for IFU)
- mem_req_wdata  out  DATA_W  registered write data
- mem_req_wmask  out  DATA_W/8  registered mask (0 for IFU)
- mem_resp_valid  in  1  downstream response
- mem_resp_rdata  in  DATA_W  downstream read data

## Operation

- FSM states: IDLE, REQ, RESP.
- IDLE: if any req_valid, arbiter picks winner; winner's req_ready = 1 combinationally in this cycle, loser's = 0; request fields and owner latched; -> REQ. No valid: stay.
- REQ: mem_req_valid = 1 with latched fields; stay until mem_req_ready = 1; -> RESP.
- RESP: owner's resp_valid = mem_resp_valid, resp_rdata = mem_resp_rdata (combinational pass-through); non-owner resp_valid = 0; on mem_resp_valid -> IDLE.
- req_ready both 0 outside IDLE. Requesters hold request until ready; requesters always accept responses (no resp_ready).
- Tie (both valid in IDLE): resolved per Configuration. Single requester always wins.
- mem_resp_valid outside RESP ignored; requester valids dropped before ready are not remembered.
- Reset: state = IDLE, all valid/ready outputs 0, latched fields 0, last-grant = LSU. Reset mid-transaction abandons it; no response delivered; downstream must be reset in the same cycle.

## Timing

- Accept cycle N (IDLE) -> mem_req_valid from N+1.
- mem_req_ready at N+1 -> RESP at N+2; earliest resp_valid N+2.
- Response cycle M -> next accept earliest M+1. Minimum turnaround 3 cycles per transaction.
- mem_req_* stable from N+1 until handshake.

## Configuration

- MEM_ARB_RR_EN defined: round-robin on ties; grant the requester not granted last; last-grant register updated on every accept; reset value LSU, so IFU wins first tie.
- Undefined: fixed priority, LSU wins every tie; last-grant register not present.

## Structure

- Package mem_arb_pkg: state enum (IDLE, REQ, RESP), owner constants (OWN_IFU, OWN_LSU).
- Sub-module arb_pick: two-input selector (valids, last-grant in; one-hot grant out), containing the MEM_ARB_RR_EN choice.

## Test plan

- IFU only: ifu addr 0x80000000, mem_req_ready same cycle, resp 0x00000413 two cycles later -> ifu_resp_valid with 0x00000413, lsu_resp_valid 0, 3-cycle turnaround.
- LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF -> mem_req_wen 1 with those fields; ack routes to lsu_resp_valid only.
- Tie, both valid for 4 transactions: with MEM_ARB_RR_EN grants IFU,LSU,IFU,LSU; without, LSU,LSU,LSU,LSU while LSU stays valid.
- Backpressure: mem_req_ready low 5 cycles -> mem_req_* stable, both req_ready 0 throughout.
- Reset (rst = 0) in RESP -> next cycle IDLE, no resp_valid; later mem_resp_valid ignored.
- Spurious mem_resp_valid in IDLE -> no resp_valid on either side.
